// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM state encoding and bit-timing derivation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned bit_cnt_width(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level UART receiver: 2-flop synchronizer, bit timer and framing FSM (8N1, LSB first).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CW  = bit_cnt_width(CPB);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;

  // Strobes are decoded in the stop-sample cycle; the loader registers them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d      = '0;
          state_d    = IDLE;
          byte_valid = rx_sync_q;
          byte_err   = !rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/uart_rx_loader.sv
// Packs received UART bytes little-endian into words and writes them to sequential BRAM addresses.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  input  logic                         load_en,
  output logic                         we,
  output logic [DATA_WIDTH-1:0]        din,
  output logic [$clog2(MEM_DEPTH)-1:0] addra,
  output logic                         done,
  output logic                         frame_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned AW    = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NB - 1);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(MEM_DEPTH - 1);

  logic [7:0] rx_byte;
  logic       byte_valid, byte_err;

  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0] pack_q, pack_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [AW-1:0]         addra_q, addra_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  frame_err_q, frame_err_d;

  uart_rx_core #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  always_comb begin
    byte_idx_d  = byte_idx_q;
    pack_d      = pack_q;
    din_d       = din_q;
    addra_d     = addra_q;
    done_d      = done_q;
    frame_err_d = frame_err_q;
    we_d        = 1'b0;
    if (!load_en) begin
      byte_idx_d  = '0;
      addra_d     = '0;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
    end else begin
      // Address advances after the write strobe; the final slot latches done instead.
      if (we_q) begin
        if (addra_q == LAST_ADDR) done_d = 1'b1;
        else                      addra_d = addra_q + 1'b1;
      end
      if (byte_err) frame_err_d = 1'b1;
      if (byte_valid && !done_q) begin
        pack_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
        if (byte_idx_q == LAST_IDX) begin
          we_d       = 1'b1;
          din_d      = pack_d;
          byte_idx_d = '0;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q  <= '0;
      pack_q      <= '0;
      din_q       <= '0;
      addra_q     <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      pack_q      <= pack_d;
      din_q       <= din_d;
      addra_q     <= addra_d;
      we_q        <= we_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign we        = we_q;
  assign din       = din_q;
  assign addra     = addra_q;
  assign done      = done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: vector table, directed corner sequences and a random run vs a word-level model.
module tb_uart_rx_loader;

  localparam int unsigned CLK_FREQ = 100000000;
  localparam int unsigned BAUD     = 1000000;
  localparam int unsigned CPB      = 100;
  localparam int unsigned DW       = 32;
  // Small memory keeps the fill/overflow run short at 1000 cycles per byte.
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned AW       = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          load_en = 1'b1;
  logic          we;
  logic [DW-1:0] din;
  logic [AW-1:0] addra;
  logic          done;
  logic          frame_err;

  always #5 clk = ~clk;

  uart_rx_loader #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_WIDTH(DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .load_en  (load_en),
    .we       (we),
    .din      (din),
    .addra    (addra),
    .done     (done),
    .frame_err(frame_err)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] act_din[$];
  int          act_addr[$];
  int          wide_we = 0;
  logic        we_prev = 1'b0;

  always @(negedge clk) begin
    if (rst_n && we) begin
      act_din.push_back(din);
      act_addr.push_back(int'(addra));
    end
    if (we && we_prev) wide_we++;
    we_prev = we;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(bad ? 1'b0 : 1'b1);
    if (bad) bit_time(1'b1);
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    rx      = 1'b1;
    load_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    act_din.delete();
    act_addr.delete();
  endtask

  // Word-level reference: good bytes accumulate LSB-first, words beyond the memory are dropped.
  logic [7:0]  sb[$];
  bit          sbad[$];
  logic [31:0] exp_w[$];
  bit          exp_ferr;

  task automatic send_logged(input logic [7:0] b, input bit bad);
    sb.push_back(b);
    sbad.push_back(bad);
    send_byte(b, bad);
  endtask

  function automatic void run_model(input int depth);
    logic [31:0] cur = '0;
    int          n = 0;
    exp_w.delete();
    exp_ferr = 1'b0;
    foreach (sb[i]) begin
      if (sbad[i]) begin
        exp_ferr = 1'b1;
      end else if (exp_w.size() < depth) begin
        cur = cur | (32'(sb[i]) << (8 * n));
        n++;
        if (n == 4) begin
          exp_w.push_back(cur);
          cur = '0;
          n = 0;
        end
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    check({tag, "_nwrites"}, 32'(act_din.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < act_din.size(); i++) begin
      check({tag, "_din"}, act_din[i], exp_w[i]);
      check({tag, "_addr"}, 32'(act_addr[i]), 32'(i));
    end
    check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
  endtask

  typedef struct {
    logic [39:0] bytes;
    logic [4:0]  bad;
    int          n;
    logic [31:0] exp_din;
    bit          exp_we;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{40'h00_12_34_56_78, 5'b00000, 4, 32'h12345678, 1'b1, 1'b0};
    vecs[1] = '{40'hEE_DD_CC_BB_AA, 5'b00010, 5, 32'hEEDDCCAA, 1'b1, 1'b1};
    vecs[2] = '{40'h00_00_03_02_01, 5'b00000, 3, 32'h00000000, 1'b0, 1'b0};
    vecs[3] = '{40'h00_00_00_00_5A, 5'b00001, 1, 32'h00000000, 1'b0, 1'b1};

    #1;
    check("reset_ctrl", {27'd0, we, done, frame_err, addra}, 32'd0);
    check("reset_din", din, 32'd0);
    do_reset();

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[8*i +: 8], vecs[v].bad[i]);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_nwrites", v), 32'(act_din.size()), vecs[v].exp_we ? 32'd1 : 32'd0);
      if (act_din.size() > 0) begin
        check($sformatf("vec%0d_wdin", v), act_din[0], vecs[v].exp_din);
        check($sformatf("vec%0d_waddr", v), 32'(act_addr[0]), 32'd0);
      end
      check($sformatf("vec%0d_din_hold", v), din, vecs[v].exp_din);
      check($sformatf("vec%0d_addra_after", v), 32'(addra), vecs[v].exp_we ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
    end

    // Short low pulse must be rejected; the receiver then frames a real word normally.
    do_reset();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_nwrites", 32'(act_din.size()), 32'd0);
    check("glitch_frame_err", 32'(frame_err), 32'd0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
    repeat (20) @(negedge clk);
    check("glitch_after_nwrites", 32'(act_din.size()), 32'd1);
    check("glitch_after_din", din, 32'hCAFEF00D);
    check("glitch_after_addra", 32'(addra), 32'd1);

    // Asynchronous reset in bit 4 of the third byte.
    act_din.delete();
    act_addr.delete();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check("midbyte_reset_ctrl", {27'd0, we, done, frame_err, addra}, 32'd0);
    check("midbyte_reset_din", din, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    repeat (20) @(negedge clk);
    check("post_reset_nwrites", 32'(act_din.size()), 32'd1);
    if (act_din.size() > 0) begin
      check("post_reset_din", act_din[0], 32'h77665544);
      check("post_reset_addr", 32'(act_addr[0]), 32'd0);
    end

    // load_en drop mid-word clears flags and restarts packing at byte 0, addra 0.
    do_reset();
    send_byte(8'h99, 1'b1);
    check("ld_frame_err_set", 32'(frame_err), 32'd1);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    load_en = 1'b0;
    repeat (5) @(negedge clk);
    check("ld_frame_err_clr", 32'(frame_err), 32'd0);
    check("ld_addra_clr", 32'(addra), 32'd0);
    send_byte(8'hB0, 1'b0);
    load_en = 1'b1;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    repeat (20) @(negedge clk);
    check("ld_nwrites", 32'(act_din.size()), 32'd1);
    if (act_din.size() > 0) begin
      check("ld_din", act_din[0], 32'hC4C3C2C1);
      check("ld_addr", 32'(act_addr[0]), 32'd0);
    end

    // Random bytes with occasional bad stop bits.
    do_reset();
    sb.delete();
    sbad.delete();
    for (int i = 0; i < 12; i++) send_logged(8'($urandom), $urandom_range(0, 5) == 0);
    repeat (20) @(negedge clk);
    run_model(DEPTH);
    compare_model("rand");

    // Fill the whole memory, then overflow by one word.
    do_reset();
    sb.delete();
    sbad.delete();
    for (int i = 0; i < 4 * (DEPTH + 1); i++) begin
      if (i == 4 * (DEPTH - 1)) begin
        repeat (5) @(negedge clk);
        check("fill_done_early", 32'(done), 32'd0);
        check("fill_addra_early", 32'(addra), 32'(DEPTH - 1));
      end
      send_logged(8'($urandom), 1'b0);
    end
    repeat (20) @(negedge clk);
    run_model(DEPTH);
    compare_model("fill");
    check("fill_done", 32'(done), 32'd1);
    check("fill_addra_hold", 32'(addra), 32'(DEPTH - 1));

    check("we_single_cycle", 32'(wide_we), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_loader.md
UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, packed word width, a multiple of 8.
REQ-004 The block SHALL have parameter MEM_DEPTH, default 64, number of words in the downstream UART BRAM.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-007 The block SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-008 The block SHALL have port load_en, input, 1 bit, arms loading; low discards data and clears pointers.
REQ-009 The block SHALL have port we, output, 1 bit, one-cycle BRAM write strobe.
REQ-010 The block SHALL have port din, output, DATA_WIDTH bits, BRAM write data.
REQ-011 The block SHALL have port addra, output, $clog2(MEM_DEPTH) bits, BRAM write address.
REQ-012 The block SHALL have port done, output, 1 bit, sticky: all MEM_DEPTH words written.
REQ-013 The block SHALL have port frame_err, output, 1 bit, sticky: at least one bad stop bit seen.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer before any use; this adds 2 cycles of input latency.
REQ-015 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD (integer division); the bit-timer counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-016 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE->START SHALL occur on a synchronized high-to-low transition of rx.
REQ-018 In START, rx SHALL be sampled at CLKS_PER_BIT/2 cycles; low->DATA, high->IDLE (glitch rejected, no byte).
REQ-019 In DATA, 8 bits SHALL be sampled LSB-first, each exactly CLKS_PER_BIT cycles after the previous sample; then ->STOP.
REQ-020 In STOP, rx SHALL be sampled CLKS_PER_BIT cycles after the last data bit; high=valid byte, low=framing error; both ->IDLE.
REQ-021 A framing-error byte SHALL be discarded, SHALL set frame_err, and SHALL NOT advance the byte index.
REQ-022 Valid bytes SHALL be packed little-endian: the first byte of a word goes to din[7:0] and byte k goes to din[8k+7:8k].
REQ-023 we SHALL pulse for exactly one cycle, the cycle after the STOP sample of byte DATA_WIDTH/8, with din and addra stable during that cycle.
REQ-024 addra SHALL increment on the cycle after each we pulse; the write to address MEM_DEPTH-1 SHALL set done instead of wrapping, and addra SHALL hold at MEM_DEPTH-1.
REQ-025 While done=1, received bytes SHALL be discarded and we SHALL stay 0.
REQ-026 While load_en=0, addra, the byte index, done and frame_err SHALL be synchronously cleared, and received bytes SHALL be discarded; the serial FSM SHALL keep running so it stays framed.
REQ-027 A load_en fall mid-word SHALL drop the partial word; the next load SHALL start at byte 0, addra 0.
REQ-028 din SHALL hold its last written value between we pulses.

Reset
REQ-029 On rst_n=0, asynchronously: FSM=IDLE, counters=0, we=0, din=0, addra=0, done=0, frame_err=0, synchronizer flops=1.
REQ-030 A reset asserted mid-byte SHALL abandon the byte; after release, the first complete word SHALL be written to addra 0.

Structure
REQ-031 The FSM state encodings and the CLKS_PER_BIT derivation SHALL live in shared package uart_pkg, reused by the UART transmitter.
REQ-032 The bit-level deserializer (synchronizer, timer, FSM) SHALL be sub-module uart_rx_core, outputting byte[7:0], byte_valid and byte_err; uart_rx_loader SHALL contain only packing, address and flag logic.

Verification
REQ-033 The bench SHALL use CLK_FREQ=100000000 and BAUD=1000000 (CLKS_PER_BIT=100) with load_en=1.
REQ-034 Scenario, single word: send 0x78,0x56,0x34,0x12 -> one we pulse, din=0x12345678, addra=0; then addra=1.
REQ-035 Scenario, fill: send 64 words -> 64 we pulses at addra 0..63, done=1 after the last; a 65th word produces no we.
REQ-036 Scenario, framing error: send 0xAA, then 0xBB with stop=0, then 0xCC,0xDD,0xEE -> frame_err=1, din=0xEEDDCCAA at addra 0.
REQ-037 Scenario, glitch: drive rx low for 20 cycles then high -> no byte, FSM back in IDLE, no we.
REQ-038 Scenario, reset and load_en: assert rst_n=0 at bit 4 of byte 2 -> outputs zero immediately; separately, drop load_en after 3 bytes -> the next 4 bytes are written at addra 0.
